// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO controller for the MIPS multiply/divide unit.
// Multiplies and MTHI/MTLO finish in one cycle. Divides run on an external
// unsigned iterative divider through a start/busy handshake, with sign
// magnitude conversion before the divide and sign correction after it.
// Optional build macro: DIVZERO_FAST_EN (a zero divisor finishes in IDLE
// with hi <= rs, lo <= all-ones, and the divider is not started).
module muldiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DSTART   = 3'd1,
    DWAIT_HI = 3'd2,
    DWAIT_LO = 3'd3,
    FIXUP    = 3'd4
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   hi_nx, lo_nx, dvd_nx, dvs_nx;
  logic           neg_q, neg_r, neg_q_nx, neg_r_nx;
  logic           start_nx;
  logic [2*W-1:0] prod_s, prod_u;
  logic           is_div_op;
  logic           div_short;

  // Two's-complement magnitude; 0x80000000 maps to itself (read as unsigned).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? ((~v) + W'(1)) : v;
  endfunction

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{W{rs[W-1]}}, rs} * {{W{rt[W-1]}}, rt};
  assign prod_u = {{W{1'b0}}, rs} * {{W{1'b0}}, rt};

  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);

`ifdef DIVZERO_FAST_EN
  assign div_short = (rt == '0);
`else
  assign div_short = 1'b0;
`endif

  // Stall covers the issue cycle of a divide and every cycle the FSM is busy.
  assign stall = busy || (op_valid && is_div_op && (state == IDLE) && !div_short);

  // Next-state, HI/LO and divider-operand logic.
  always_comb begin
    state_nx = state;
    hi_nx    = hi;
    lo_nx    = lo;
    dvd_nx   = div_dividend;
    dvs_nx   = div_divisor;
    neg_q_nx = neg_q;
    neg_r_nx = neg_r;
    start_nx = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT:  {hi_nx, lo_nx} = prod_s;
            OP_MULTU: {hi_nx, lo_nx} = prod_u;
            OP_MTHI:  hi_nx = rs;
            OP_MTLO:  lo_nx = rs;
            OP_DIV, OP_DIVU: begin
              if (div_short) begin
                hi_nx = rs;
                lo_nx = '1;
              end else begin
                dvd_nx   = (op == OP_DIV) ? mag(rs) : rs;
                dvs_nx   = (op == OP_DIV) ? mag(rt) : rt;
                neg_q_nx = (op == OP_DIV) && (rs[W-1] != rt[W-1]);
                neg_r_nx = (op == OP_DIV) && rs[W-1];
                start_nx = 1'b1;
                state_nx = DSTART;
              end
            end
            default: ;
          endcase
        end
      end
      DSTART:   state_nx = DWAIT_HI;
      DWAIT_HI: if (div_busy)  state_nx = DWAIT_LO;
      DWAIT_LO: if (!div_busy) state_nx = FIXUP;
      FIXUP: begin
        lo_nx    = neg_q ? ((~div_q) + W'(1)) : div_q;
        hi_nx    = neg_r ? ((~div_r) + W'(1)) : div_r;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight divide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hi           <= '0;
      lo           <= '0;
      busy         <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
    end else begin
      state        <= state_nx;
      hi           <= hi_nx;
      lo           <= lo_nx;
      busy         <= (state_nx != IDLE);
      div_start    <= start_nx;
      div_dividend <= dvd_nx;
      div_divisor  <= dvs_nx;
      neg_q        <= neg_q_nx;
      neg_r        <= neg_r_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural iterative-divider model.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] hi, lo;
  logic        busy, stall, div_start;
  logic [31:0] div_dividend, div_divisor;
  logic        div_busy;
  logic [31:0] div_q, div_r;

  int errors = 0;
  int checks = 0;

`ifdef DIVZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_ctrl dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;

  // Divider model: start latency and busy length are set per test.
  int start_lat = 0;
  int busy_len  = 4;
  int phase, dcnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      phase    <= 0;
      dcnt     <= 0;
      div_q    <= '0;
      div_r    <= '0;
    end else begin
      case (phase)
        0: if (div_start) begin
          phase <= 1;
          dcnt  <= start_lat;
          div_q <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
          div_r <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end
        1: if (dcnt == 0) begin
          div_busy <= 1'b1;
          dcnt     <= busy_len;
          phase    <= 2;
        end else dcnt <= dcnt - 1;
        default: if (dcnt <= 1) begin
          div_busy <= 1'b0;
          phase    <= 0;
        end else dcnt <= dcnt - 1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single-cycle op: stall must stay low, result visible after the accepting edge.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clock);
    op_valid = 1'b1; op = o; rs = a; rt = b;
    #1 check({tag, " stall"}, 64'(stall), 64'(0));
    @(negedge clock);
    op_valid = 1'b0;
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " busy"}, 64'(busy), 64'(0));
  endtask

  // Divide: drop the request after the accepting edge and follow the handshake.
  task automatic do_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int blen,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [31:0] exp_dvd);
    logic [31:0] old_hi, old_lo;
    int stall_cnt, starts, bcnt, gap, n;
    bit hold_ok, start_ok, fast;
    fast = FAST && (b == 0);
    start_lat = lat; busy_len = blen;
    stall_cnt = 0; starts = 0; bcnt = 0; gap = 0; n = 0;
    hold_ok = 1'b1; start_ok = 1'b1;
    @(negedge clock);
    old_hi = hi; old_lo = lo;
    op_valid = 1'b1; op = o; rs = a; rt = b;
    #1 if (stall) stall_cnt++;
    @(negedge clock);
    op_valid = 1'b0;
    while (busy && n < 200) begin
      if (stall) stall_cnt++;
      if (div_start) starts++;
      if (div_start && div_busy) start_ok = 1'b0;
      if (div_busy) bcnt++;
      else if (starts > 0 && !div_start && bcnt == 0) gap++;
      if (hi != old_hi || lo != old_lo) hold_ok = 1'b0;
      n++;
      @(negedge clock);
    end
    check({tag, " timeout"}, 64'(n >= 200), 64'(0));
    check({tag, " stall after"}, 64'(stall), 64'(0));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    if (fast) begin
      check({tag, " starts"}, 64'(starts), 64'(0));
      check({tag, " stall cycles"}, 64'(stall_cnt), 64'(0));
    end else begin
      check({tag, " starts"}, 64'(starts), 64'(1));
      check({tag, " start vs busy"}, 64'(start_ok), 64'(1));
      check({tag, " busy len"}, 64'(bcnt), 64'(blen));
      check({tag, " stall cycles"}, 64'(stall_cnt), 64'(4 + bcnt + gap));
      check({tag, " hold"}, 64'(hold_ok), 64'(1));
      check({tag, " dividend"}, 64'(div_dividend), 64'(exp_dvd));
    end
  endtask

  initial begin
    int n, starts;
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs = '0; rt = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst hi", 64'(hi), 64'(0));
    check("rst lo", 64'(lo), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst stall", 64'(stall), 64'(0));
    check("rst start", 64'(div_start), 64'(0));
    check("rst dvd", 64'(div_dividend), 64'(0));
    check("rst dvs", 64'(div_divisor), 64'(0));

    do_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("mthi", 3'd5, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFA);
    do_op("mtlo", 3'd6, 32'h0000_ABCD, 32'd9, 32'h0000_1234, 32'h0000_ABCD);
    do_op("resv", 3'd7, 32'h5555_5555, 32'd9, 32'h0000_1234, 32'h0000_ABCD);
    do_op("multu max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // Reset during DWAIT_LO.
    start_lat = 1; busy_len = 6;
    @(negedge clock);
    op_valid = 1'b1; op = 3'd4; rs = 32'd100; rt = 32'd7;
    @(negedge clock);
    op_valid = 1'b0;
    n = 0;
    while (!div_busy && n < 50) begin n++; @(negedge clock); end
    @(negedge clock);
    check("mid busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("mid rst hi", 64'(hi), 64'(0));
    check("mid rst lo", 64'(lo), 64'(0));
    check("mid rst busy", 64'(busy), 64'(0));
    check("mid rst dvd", 64'(div_dividend), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (div_start) starts++;
    end
    check("post rst starts", 64'(starts), 64'(0));
    check("post rst busy", 64'(busy), 64'(0));
    do_op("multu 3x5", 3'd2, 32'd3, 32'd5, 32'd0, 32'd15);

    do_div("divu 100/7", 3'd4, 32'd100, 32'd7, 0, 5, 32'd2, 32'd14, 32'd100);
    do_div("div -100/7", 3'd3, 32'hFFFF_FF9C, 32'd7, 2, 3, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd100);
    do_div("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 2, 32'd0, 32'h8000_0000, 32'h8000_0000);
    do_div("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 0, 1, 32'd1, 32'hFFFF_FFFD, 32'd7);
    do_div("divu 5/0", 3'd4, 32'd5, 32'd0, 1, 4, 32'd5, 32'hFFFF_FFFF, 32'd5);
    do_op("mult after", 3'd1, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Controller for the HI/LO unit of the single-cycle MIPS CPU. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and computes multiplies in one cycle. Divides are sequenced through the shared iterative unsigned divider via a start/busy handshake, with sign pre- and post-correction applied for signed DIV. It owns the HI and LO architectural registers and generates the pipeline stall while a divide is in flight.

## Interface
Parameters:
- none. Width is fixed at 32 bits.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- op_valid  in  1  request present this cycle
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- rs  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt  in  32  operand B (divisor / multiplier)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  registered; high whenever the FSM is not in IDLE
- stall  out  1  combinational; busy OR (op_valid AND op∈{DIV,DIVU} AND FSM in IDLE AND divide not short-circuited)
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  32  registered magnitude of the dividend
- div_divisor  out  32  registered magnitude of the divisor
- div_busy  in  1  divider busy
- div_q  in  32  divider quotient (unsigned)
- div_r  in  32  divider remainder (unsigned)

## Operation
- FSM states: IDLE, DSTART, DWAIT_HI, DWAIT_LO, FIXUP.
- IDLE, op_valid:
  - MULT: {hi,lo} ← signed rs×rt (64 bits).
  - MULTU: {hi,lo} ← unsigned rs×rt.
  - MTHI: hi ← rs.
  - MTLO: lo ← rs.
  - All of these complete in the same cycle; the FSM stays in IDLE.
- IDLE, DIV/DIVU accepted:
  - Latch the operand magnitudes into div_dividend/div_divisor. For DIVU these are the raw operands. For DIV each negative operand is negated (two's complement); 0x80000000 stays 0x80000000 and is treated as unsigned.
  - Latch neg_q = DIV and rs[31]≠rt[31]; latch neg_r = DIV and rs[31].
  - Go to DSTART.
- DSTART: div_start=1 for exactly this cycle; go to DWAIT_HI.
- DWAIT_HI: stay until div_busy=1, then go to DWAIT_LO.
- DWAIT_LO: stay until div_busy=0, then go to FIXUP.
- FIXUP: lo ← neg_q ? −div_q : div_q; hi ← neg_r ? −div_r : div_r; go to IDLE.
- In non-IDLE states, op/op_valid are ignored. The CPU holds the instruction while stall=1.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- Reset values, including on reset asserted mid-divide:
  - state=IDLE, hi=0, lo=0, busy=0, div_start=0, div_dividend=0, div_divisor=0.
  - Any in-flight divide result is discarded.

## Timing
- MULT/MULTU/MTHI/MTLO: zero stall. The result is visible on hi/lo after the accepting edge.
- DIV/DIVU: stall is high in the issue cycle and stays high until the FIXUP edge. hi/lo update on that edge, and busy/stall drop in the next cycle.
- Total stall cycles = 4 + (cycles div_busy is high) + (cycles between div_start and div_busy rising).
- div_start never asserts in consecutive cycles, and never while div_busy=1.
- hi/lo hold their old values throughout a divide. Software MFHI/MFLO reads are stalled by the CPU via busy.

## Configuration
- DIVZERO_FAST_EN defined:
  - DIV/DIVU with rt=0 completes in IDLE on the accepting edge, like MULT.
  - Result: hi ← rs, lo ← 0xFFFFFFFF; stall stays low; the divider is not started.
- DIVZERO_FAST_EN undefined:
  - A zero divisor goes through the full divider sequence.
  - hi/lo are whatever the sign-corrected divider outputs give.

## Test plan
- Reset mid-divide: assert reset during DWAIT_LO → hi=lo=0, busy=0, no div_start afterwards; next MULTU 3×5 → lo=15, hi=0.
- MULT 0xFFFFFFFE × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, stall never high; then MTHI 0x1234 → hi=0x1234, lo unchanged.
- DIVU 100/7 → one div_start pulse, stall held through DWAIT_LO, then lo=14, hi=2, busy low one cycle after FIXUP.
- DIV −100/7 → lo=0xFFFFFFF2 (−14), hi=0xFFFFFFFE (−2).
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0:
  - With DIVZERO_FAST_EN: hi=5, lo=0xFFFFFFFF, no div_start, stall low.
  - Without it: full handshake, then hi/lo equal the divider outputs.
